// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard/flush control bundle: decoded instruction and branch outcome in; pipeline enables and status out.
interface hazard_ctrl_if;
    logic [31:0] id_ir;
    logic        id_valid;
    logic        ex_taken;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_ir, id_valid, ex_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_ir, id_valid, ex_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: RAW scoreboard stall, branch/jump flush; enables are combinational (0-cycle latency).
// Backpressure: a RAW hazard holds PC and IF/ID and bubbles ID/EX until the source retires.
module hazard_ctrl #(
    parameter int WB_LAT    = 3,
    parameter int FLUSH_LEN = 2
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [2:0] WB_INIT    = 3'(WB_LAT);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_LEN - 1);

    state_t      st;
    logic [2:0]  fcount;
    logic [15:0] stall_q;
    logic [15:0] flush_q;
    logic [2:0]  busy [32];

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, dest;
    logic        use_rs, use_rt, is_jump;
    logic        hazard, issue;
    logic        unused_imm;

    assign op = bus.id_ir[31:26];
    assign rs = bus.id_ir[25:21];
    assign rt = bus.id_ir[20:16];
    assign rd = bus.id_ir[15:11];
    assign unused_imm = ^bus.id_ir[10:0];

    always_comb begin
        use_rs  = 1'b1;
        use_rt  = 1'b0;
        dest    = 5'd0;
        is_jump = 1'b0;
        case (op)
            6'h00: begin
                use_rt = 1'b1;
                dest   = rd;
            end
            6'h23, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F:
                dest = rt;
            6'h2B, 6'h04, 6'h05:
                use_rt = 1'b1;
            6'h02: begin
                use_rs  = 1'b0;
                is_jump = 1'b1;
            end
            6'h03: begin
                use_rs  = 1'b0;
                is_jump = 1'b1;
                dest    = 5'd31;
            end
            default: ;
        endcase
    end

    // r0 never reads as busy, so a write to r0 can never stall a reader.
    assign hazard = bus.id_valid &
                    ((use_rs & (rs != 5'd0) & (busy[rs] != 3'd0)) |
                     (use_rt & (rt != 5'd0) & (busy[rt] != 3'd0)));

    // A STALL cycle whose hazard has just cleared issues like RUN, so the
    // consumer leaves ID in the same cycle its source retires.
    assign issue = bus.id_valid & (st != FLUSH) & ~hazard & ~bus.ex_taken;

    always_comb begin
        bus.pc_we       = 1'b1;
        bus.ifid_we     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = ~bus.id_valid;
        if (rst) begin
            bus.pc_we       = 1'b0;
            bus.ifid_we     = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (st == FLUSH || bus.ex_taken) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (hazard) begin
            bus.pc_we       = 1'b0;
            bus.ifid_we     = 1'b0;
            bus.idex_bubble = 1'b1;
        end else begin
            bus.ifid_flush  = is_jump & bus.id_valid;
        end
    end

    assign bus.state     = st;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= RUN;
            fcount  <= 3'd0;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
            for (int r = 0; r < 32; r++) busy[r] <= 3'd0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (r == 0)
                    busy[r] <= 3'd0;
                else if (issue && dest == 5'(r))
                    busy[r] <= WB_INIT;
                else if (busy[r] != 3'd0)
                    busy[r] <= busy[r] - 3'd1;
            end

            case (st)
                RUN, STALL: begin
                    if (bus.ex_taken) begin
                        st     <= FLUSH;
                        fcount <= FLUSH_INIT;
                        if (flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
                    end else if (hazard) begin
                        st <= STALL;
                        if (st == STALL && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
                    end else begin
                        st <= RUN;
                    end
                end
                FLUSH: begin
                    if (fcount == 3'd0) st <= RUN;
                    else                fcount <= fcount - 3'd1;
                end
                default: st <= RUN;
            endcase
        end
    end
endmodule
